// File: rtl/pipe_exec_ctl_pkg.sv
// Shared state codes and defaults for the pipeline execution controller.
package pipe_exec_ctl_pkg;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } exec_state_t;

   localparam int unsigned DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse on an
// accepted press.
module btn_debounce #(
   parameter int unsigned P_DEBOUNCE_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CW = (P_DEBOUNCE_CYCLES > 1) ?
                       $clog2(P_DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(P_DEBOUNCE_CYCLES - 1);

   logic          s1, s2;
   logic          lvl;
   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         lvl     <= 1'b0;
         cnt     <= '0;
         o_pulse <= 1'b0;
      end else begin
         s1      <= i_btn;
         s2      <= s1;
         o_pulse <= 1'b0;
         // Any sample equal to the accepted level restarts the count.
         if (s2 != lvl) begin
            if (cnt == CNT_MAX) begin
               lvl     <= s2;
               cnt     <= '0;
               o_pulse <= s2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/pipe_exec_ctl.sv
// Run/halt/step/breakpoint controller producing the pipeline clock
// enable.
module pipe_exec_ctl
   import pipe_exec_ctl_pkg::*;
#(
   parameter int unsigned P_DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned P_STEP_W          = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_btn_run,
   input  logic                i_btn_step,
   input  logic [P_STEP_W-1:0] i_step_count,
   input  logic                i_bp_en,
   input  logic [31:0]         i_bp_addr,
   input  logic [31:0]         i_pc_f,
   output logic                o_clk_en,
   output logic                o_halted,
   output logic [1:0]          o_state,
   output logic [31:0]         o_cycle_cnt
);

   exec_state_t         state_q, state_d;
   logic [P_STEP_W-1:0] remaining, rem_d;
   logic [P_STEP_W-1:0] rem_load;
   logic                bp_skip, skip_d;
   logic [31:0]         cycle_q;
   logic                run_p, step_p;
   logic                bp_hit;

   btn_debounce #(.P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)) u_run (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn_run),
      .o_pulse (run_p)
   );

   btn_debounce #(.P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)) u_step (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn_step),
      .o_pulse (step_p)
   );

   assign rem_load = (i_step_count == '0) ?
                     P_STEP_W'(1) : i_step_count;

   assign bp_hit = i_bp_en & (i_pc_f == i_bp_addr) & ~bp_skip;

   assign o_clk_en = ((state_q == ST_RUN) | (state_q == ST_STEP))
                     & ~bp_hit;

   always_comb begin
      state_d = state_q;
      rem_d   = remaining;
      skip_d  = bp_skip;
      // Skip covers only the first enabled cycle off the breakpoint.
      if (o_clk_en) skip_d = 1'b0;
      unique case (state_q)
         ST_HALT: begin
            if (run_p) begin
               state_d = ST_RUN;
            end else if (step_p) begin
               state_d = ST_STEP;
               rem_d   = rem_load;
            end
         end
         ST_RUN: begin
            if (run_p)       state_d = ST_HALT;
            else if (bp_hit) state_d = ST_BREAK;
         end
         ST_STEP: begin
            if (o_clk_en) rem_d = remaining - 1'b1;
            if (run_p)       state_d = ST_HALT;
            else if (bp_hit) state_d = ST_BREAK;
            else if (o_clk_en && remaining == P_STEP_W'(1))
               state_d = ST_HALT;
         end
         ST_BREAK: begin
            if (run_p) begin
               state_d = ST_RUN;
               skip_d  = 1'b1;
            end else if (step_p) begin
               state_d = ST_STEP;
               rem_d   = rem_load;
               skip_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_HALT;
         remaining <= '0;
         bp_skip   <= 1'b0;
         cycle_q   <= '0;
      end else begin
         state_q   <= state_d;
         remaining <= rem_d;
         bp_skip   <= skip_d;
         if (o_clk_en) cycle_q <= cycle_q + 32'd1;
      end
   end

   assign o_halted    = (state_q == ST_HALT) | (state_q == ST_BREAK);
   assign o_state     = state_q;
   assign o_cycle_cnt = cycle_q;

endmodule

// File: tb/tb_pipe_exec_ctl.sv
// Directed bench for pipe_exec_ctl with a short debounce window.
module tb_pipe_exec_ctl;

   logic        i_clk;
   logic        i_rst;
   logic        i_btn_run;
   logic        i_btn_step;
   logic [7:0]  i_step_count;
   logic        i_bp_en;
   logic [31:0] i_bp_addr;
   logic [31:0] i_pc_f;
   logic        o_clk_en;
   logic        o_halted;
   logic [1:0]  o_state;
   logic [31:0] o_cycle_cnt;

   int total = 0;
   int bad   = 0;

   int en_seen = 0;
   int en_rises = 0;
   int runp_seen = 0;
   logic en_prev = 1'b0;

   logic [31:0] pc;
   logic        pc_clr;

   pipe_exec_ctl #(.P_DEBOUNCE_CYCLES(4), .P_STEP_W(8)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_btn_run    (i_btn_run),
      .i_btn_step   (i_btn_step),
      .i_step_count (i_step_count),
      .i_bp_en      (i_bp_en),
      .i_bp_addr    (i_bp_addr),
      .i_pc_f       (i_pc_f),
      .o_clk_en     (o_clk_en),
      .o_halted     (o_halted),
      .o_state      (o_state),
      .o_cycle_cnt  (o_cycle_cnt)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Fetch PC model: advances by 4 on each enabled cycle.
   always @(posedge i_clk) begin
      if (pc_clr)        pc <= 32'd0;
      else if (o_clk_en) pc <= pc + 32'd4;
   end
   assign i_pc_f = pc;

   always @(negedge i_clk) begin
      if (o_clk_en) en_seen++;
      if (o_clk_en && !en_prev) en_rises++;
      en_prev = o_clk_en;
      if (dut.run_p) runp_seen++;
   end

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      i_btn_run = 1'b0;
      i_btn_step = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic press(input logic r, input logic s);
      @(negedge i_clk);
      i_btn_run = r;
      i_btn_step = s;
      repeat (10) @(negedge i_clk);
      i_btn_run = 1'b0;
      i_btn_step = 1'b0;
      repeat (10) @(negedge i_clk);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (o_clk_en !== 1'b0 || o_halted !== 1'b1 ||
          o_state !== 2'd0 || o_cycle_cnt !== 32'd0) begin
         bad++;
         $display("FAIL reset: en=%b halted=%b state=%0d cnt=%0d, need 0 1 0 0",
                  o_clk_en, o_halted, o_state, o_cycle_cnt);
      end
   endtask

   task automatic test_run_halt();
      int p0;
      do_reset();
      p0 = runp_seen;
      @(negedge i_clk) i_btn_run = 1'b1;
      @(negedge i_clk) i_btn_run = 1'b0;
      @(negedge i_clk) i_btn_run = 1'b1;
      repeat (6) @(negedge i_clk);
      total++;
      if (o_clk_en !== 1'b0) begin
         bad++;
         $display("FAIL run_early: en=%b need 0", o_clk_en);
      end
      @(negedge i_clk);
      total++;
      if (o_clk_en !== 1'b1 || o_state !== 2'd1) begin
         bad++;
         $display("FAIL run_start: en=%b state=%0d need 1 1", o_clk_en, o_state);
      end
      repeat (1) @(negedge i_clk);
      i_btn_run = 1'b0;
      repeat (10) @(negedge i_clk);
      total++;
      if (runp_seen - p0 !== 1) begin
         bad++;
         $display("FAIL run_pulses: got %0d need 1", runp_seen - p0);
      end
      press(1'b1, 1'b0);
      total++;
      if (o_state !== 2'd0 || o_clk_en !== 1'b0 || o_halted !== 1'b1) begin
         bad++;
         $display("FAIL run_halt: state=%0d en=%b need 0 0", o_state, o_clk_en);
      end
   endtask

   task automatic test_step();
      int e0, r0;
      do_reset();
      i_step_count = 8'd5;
      e0 = en_seen;
      r0 = en_rises;
      press(1'b0, 1'b1);
      total++;
      if (en_seen - e0 !== 5 || en_rises - r0 !== 1) begin
         bad++;
         $display("FAIL step5_en: cycles=%0d bursts=%0d need 5 1",
                  en_seen - e0, en_rises - r0);
      end
      total++;
      if (o_cycle_cnt !== 32'd5 || o_state !== 2'd0) begin
         bad++;
         $display("FAIL step5_cnt: cnt=%0d state=%0d need 5 0", o_cycle_cnt, o_state);
      end
      i_step_count = 8'd0;
      e0 = en_seen;
      press(1'b0, 1'b1);
      total++;
      if (en_seen - e0 !== 1 || o_cycle_cnt !== 32'd6 || o_state !== 2'd0) begin
         bad++;
         $display("FAIL step0: cycles=%0d cnt=%0d state=%0d need 1 6 0",
                  en_seen - e0, o_cycle_cnt, o_state);
      end
   endtask

   task automatic test_breakpoint();
      int k;
      do_reset();
      pc_clr = 1'b0;
      i_bp_en = 1'b1;
      i_bp_addr = 32'h10;
      @(negedge i_clk) i_btn_run = 1'b1;
      k = 0;
      while (pc !== 32'h10 && k < 30) begin
         @(negedge i_clk);
         k++;
      end
      total++;
      if (pc !== 32'h10 || o_clk_en !== 1'b0) begin
         bad++;
         $display("FAIL bp_stop: pc=%h en=%b need 00000010 0", pc, o_clk_en);
      end
      @(negedge i_clk);
      i_btn_run = 1'b0;
      total++;
      if (o_state !== 2'd3 || o_halted !== 1'b1) begin
         bad++;
         $display("FAIL bp_state: state=%0d halted=%b need 3 1", o_state, o_halted);
      end
      repeat (10) @(negedge i_clk);
      total++;
      if (pc !== 32'h10 || o_state !== 2'd3) begin
         bad++;
         $display("FAIL bp_hold: pc=%h state=%0d need 00000010 3", pc, o_state);
      end
      i_btn_run = 1'b1;
      k = 0;
      while (o_clk_en !== 1'b1 && k < 20) begin
         @(negedge i_clk);
         k++;
      end
      total++;
      if (o_clk_en !== 1'b1 || pc !== 32'h10) begin
         bad++;
         $display("FAIL bp_resume: en=%b pc=%h need 1 00000010", o_clk_en, pc);
      end
      @(negedge i_clk);
      total++;
      if (pc !== 32'h14 || o_clk_en !== 1'b1 || o_state !== 2'd1) begin
         bad++;
         $display("FAIL bp_leave: pc=%h en=%b state=%0d need 00000014 1 1",
                  pc, o_clk_en, o_state);
      end
      i_btn_run = 1'b0;
      repeat (10) @(negedge i_clk);
      press(1'b1, 1'b0);
      i_bp_en = 1'b0;
      pc_clr = 1'b1;
   endtask

   task automatic test_conflicts();
      int k;
      logic [31:0] snap;
      do_reset();
      i_step_count = 8'd9;
      press(1'b1, 1'b1);
      total++;
      if (o_state !== 2'd1 || dut.remaining !== 8'd0) begin
         bad++;
         $display("FAIL both_btn: state=%0d rem=%0d need 1 0", o_state, dut.remaining);
      end
      press(1'b1, 1'b0);
      i_step_count = 8'd200;
      press(1'b0, 1'b1);
      total++;
      if (o_state !== 2'd2) begin
         bad++;
         $display("FAIL long_step: state=%0d need 2", o_state);
      end
      @(negedge i_clk) i_btn_run = 1'b1;
      k = 0;
      while (o_state === 2'd2 && k < 20) begin
         @(negedge i_clk);
         k++;
      end
      total++;
      if (o_state !== 2'd0 || o_clk_en !== 1'b0) begin
         bad++;
         $display("FAIL step_abort: state=%0d en=%b need 0 0", o_state, o_clk_en);
      end
      snap = o_cycle_cnt;
      repeat (5) @(negedge i_clk);
      total++;
      if (o_cycle_cnt !== snap || snap >= 32'd200) begin
         bad++;
         $display("FAIL abort_cnt: cnt=%0d was %0d need unchanged below 200",
                  o_cycle_cnt, snap);
      end
      i_btn_run = 1'b0;
      repeat (10) @(negedge i_clk);
   endtask

   task automatic test_reset_mid();
      int k;
      do_reset();
      i_step_count = 8'd5;
      @(negedge i_clk) i_btn_step = 1'b1;
      k = 0;
      while (!(o_state === 2'd2 && dut.remaining === 8'd3) && k < 30) begin
         @(negedge i_clk);
         k++;
      end
      total++;
      if (dut.remaining !== 8'd3 || o_state !== 2'd2) begin
         bad++;
         $display("FAIL mid_setup: rem=%0d state=%0d need 3 2", dut.remaining, o_state);
      end
      i_rst = 1'b1;
      i_btn_step = 1'b0;
      @(negedge i_clk);
      total++;
      if (o_state !== 2'd0 || o_clk_en !== 1'b0 || o_cycle_cnt !== 32'd0) begin
         bad++;
         $display("FAIL mid_reset: state=%0d en=%b cnt=%0d need 0 0 0",
                  o_state, o_clk_en, o_cycle_cnt);
      end
      i_rst = 1'b0;
      repeat (12) @(negedge i_clk);
      total++;
      if (o_state !== 2'd0 || o_cycle_cnt !== 32'd0) begin
         bad++;
         $display("FAIL mid_after: state=%0d cnt=%0d need 0 0", o_state, o_cycle_cnt);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      press(1'b1, 1'b0);
      @(negedge i_clk);
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      @(negedge i_clk);
      total++;
      if (o_cycle_cnt !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL wrap_max: cnt=%h need ffffffff", o_cycle_cnt);
      end
      @(negedge i_clk);
      total++;
      if (o_cycle_cnt !== 32'h0000_0000) begin
         bad++;
         $display("FAIL wrap_zero: cnt=%h need 00000000", o_cycle_cnt);
      end
      press(1'b1, 1'b0);
   endtask

   initial begin
      i_rst = 1'b1;
      i_btn_run = 1'b0;
      i_btn_step = 1'b0;
      i_step_count = 8'd1;
      i_bp_en = 1'b0;
      i_bp_addr = 32'h0;
      pc_clr = 1'b1;
      test_reset();
      test_run_halt();
      test_step();
      test_breakpoint();
      test_conflicts();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
